// File: rtl/console_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : console_uart_tx
// Description : Memory-mapped console UART transmitter (8N1) with TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module console_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        tx,
    output logic        busy
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    state_t           state_q;
    state_t           state_d;
    logic [15:0]      div_q;
    logic [15:0]      div_d;
    logic [2:0]       bit_q;
    logic [2:0]       bit_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             tx_q;
    logic             tx_d;
    logic             ready_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;

    logic             hit;
    logic             is_write;
    logic             push_req;
    logic             accept;
    logic             push;
    logic             pop;
    logic             div_wrap;
    logic [8:0]       count_ext;
    logic             unused_wdata;

    assign hit          = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign is_write     = |mem_wstrb;
    assign push_req     = is_write && mem_wstrb[0] && (mem_addr[2:0] == 3'd0);
    // A full FIFO still accepts a push in the same cycle the FSM pops a byte.
    assign accept       = hit && !ready_q && (!push_req || (count_q != CNT_FULL) || pop);
    assign push         = accept && push_req;
    assign busy         = (state_q != S_IDLE) || (count_q != '0);
    assign count_ext    = 9'(count_q);
    assign div_wrap     = (div_q == DIV_LAST);
    assign count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    assign unused_wdata = ^mem_wdata[31:8];

    assign tx        = tx_q;
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

    always_comb begin
        rdata_d = '0;
        if (accept && !is_write && (mem_addr[2:0] == 3'd4)) begin
            rdata_d = {23'b0, busy, count_ext[7:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    div_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_wrap) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_DATA: begin
                if (div_wrap) begin
                    div_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_STOP: begin
                if (div_wrap) begin
                    div_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = fifo_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line driver is registered from the current state, so the wire lags the FSM by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= accept;
            rdata_q <= rdata_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_console_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_console_uart_tx
// Description : Directed self-checking bench for console_uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 10 * CLK_DIV;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        tx;
    logic        busy;

    always #5 clk = ~clk;

    console_uart_tx #(
        .BASE_ADDR (32'h1000_0000),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .tx       (tx),
        .busy     (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         rst_cnt   = 0;
    int         frame_err = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_b[6];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn) rst_cnt <= rst_cnt + 1;
    end

    // Line receiver: samples mid-bit; frames cut short by a reset are dropped.
    initial begin
        int         t0;
        int         r0;
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t0 = cyc;
                r0 = rst_cnt;
                ok = 1'b1;
                repeat (CLK_DIV / 2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                if (rst_cnt == r0) begin
                    if (!ok) frame_err++;
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int tmo, output bit got, output logic [31:0] rd, output int waited);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        got       = 1'b0;
        rd        = '0;
        waited    = 0;
        while (!got && waited < tmo) begin
            @(negedge clk);
            waited++;
            if (mem_ready === 1'b1) begin
                got = 1'b1;
                rd  = mem_rdata;
            end
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(busy === 1'b0 && tx === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle wait bound", 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        rx_q.delete();
        rx_t.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int bound);
        int k;
        k = 0;
        while (rx_q.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("rx frame count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic check_frames(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) begin
                check($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_b[i]));
                if (i > 0) begin
                    check($sformatf("%s gap%0d", tag, i), 32'(rx_t[i] - rx_t[i-1]), 32'(FRAME));
                end
            end
        end
    endtask

    initial begin
        vec_t        vecs[8];
        bit          got;
        logic [31:0] rd;
        int          w;
        int          waits[6];
        int          k;
        int          lowcnt;

        vecs[0] = '{32'h1000_0004, 32'h0,  4'b0000, 1'b1, 32'h0};
        vecs[1] = '{32'h1000_0000, 32'h0,  4'b0000, 1'b1, 32'h0};
        vecs[2] = '{32'h1000_0004, 32'hFF, 4'b1111, 1'b1, 32'h0};
        vecs[3] = '{32'h1000_0000, 32'hAA, 4'b0010, 1'b1, 32'h0};
        vecs[4] = '{32'h1000_0008, 32'h0,  4'b0000, 1'b0, 32'h0};
        vecs[5] = '{32'h0FFF_FFF8, 32'hAA, 4'b0001, 1'b0, 32'h0};
        vecs[6] = '{32'h1000_0007, 32'h0,  4'b0000, 1'b1, 32'h0};
        vecs[7] = '{32'h1000_0004, 32'h0,  4'b0000, 1'b1, 32'h0};

        resetn = 1'b0;
        repeat (4) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset mem_ready", 32'(mem_ready), 32'd0);
        check("reset mem_rdata", mem_rdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            bus_op(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 6, got, rd, w);
            check($sformatf("vec%0d ready", i), 32'(got), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_ready) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
        end
        check("no frames from table", 32'(rx_q.size()), 32'd0);

        // Request held across completion: ready is a single-cycle pulse.
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0004;
        mem_wstrb = 4'b0000;
        @(negedge clk);
        check("hold c0 ready", 32'(mem_ready), 32'd0);
        @(negedge clk);
        check("hold c1 ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        check("hold c2 ready", 32'(mem_ready), 32'd0);
        check("hold c2 rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        @(posedge clk);
        #1;

        // Single byte 0x55 into an idle block.
        bus_op(32'h1000_0000, 32'h55, 4'b0001, 20, got, rd, w);
        check("0x55 ready", 32'(got), 32'd1);
        check("0x55 ready latency", 32'(w), 32'd2);
        @(negedge clk);
        check("tx +1 still idle", 32'(tx), 32'd1);
        @(negedge clk);
        check("tx +2 start bit", 32'(tx), 32'd0);
        repeat (38) @(negedge clk);
        check("busy before frame end", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy after frame end", 32'(busy), 32'd0);
        wait_rx(1, 20);
        exp_b[0] = 8'h55;
        check_frames(1, "0x55");

        // Three quick writes then status: one popped, two queued.
        wait_idle();
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            bus_op(32'h1000_0000, 32'(exp_b[i]), 4'b0001, 20, got, rd, w);
            check($sformatf("quick w%0d ready", i), 32'(got), 32'd1);
        end
        bus_op(32'h1000_0004, 32'h0, 4'b0000, 20, got, rd, w);
        check("status after 3 writes", rd, 32'h0000_0102);
        wait_rx(3, 3 * FRAME + 100);
        check_frames(3, "quick");

        // Six writes into a 4-deep FIFO: the last stalls until a pop.
        wait_idle();
        exp_b[0] = 8'hA1; exp_b[1] = 8'h5B; exp_b[2] = 8'hC3;
        exp_b[3] = 8'h0F; exp_b[4] = 8'hE7; exp_b[5] = 8'h96;
        for (int i = 0; i < 6; i++) begin
            bus_op(32'h1000_0000, 32'(exp_b[i]), 4'b0001, 200, got, rd, waits[i]);
            check($sformatf("burst w%0d ready", i), 32'(got), 32'd1);
        end
        check("burst w6 stalled", 32'(waits[5] > 2), 32'd1);
        bus_op(32'h1000_0004, 32'h0, 4'b0000, 20, got, rd, w);
        check("status full after push-on-pop", rd, 32'h0000_0104);
        wait_rx(6, 6 * FRAME + 100);
        check_frames(6, "burst");

        // Reset pulse during data bit 3 with two bytes queued.
        wait_idle();
        bus_op(32'h1000_0000, 32'h3C, 4'b0001, 20, got, rd, w);
        bus_op(32'h1000_0000, 32'hC3, 4'b0001, 20, got, rd, w);
        bus_op(32'h1000_0000, 32'h5A, 4'b0001, 20, got, rd, w);
        k = 0;
        while (tx !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("abort: start seen", 32'(tx), 32'd0);
        repeat (17) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("abort tx", 32'(tx), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort mem_ready", 32'(mem_ready), 32'd0);
        @(posedge clk);
        #1;
        bus_op(32'h1000_0004, 32'h0, 4'b0000, 20, got, rd, w);
        check("abort status ready", 32'(got), 32'd1);
        check("abort status", rd, 32'h0);
        lowcnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lowcnt++;
        end
        check("abort no further frames", 32'(lowcnt), 32'd0);
        check("abort frames received", 32'(rx_q.size()), 32'd0);

        check("framing errors", 32'(frame_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
